// File: rtl/ttuart_tx_arbiter_if.sv
// Requester-side and TX-side handshake bundle for ttuart_tx_arbiter (optional req_last under TTUART_ARB_LOCK_EN).
// Latency: none, wires only.
// Backpressure: req_ready is driven by the arbiter (slave); tx_data_done is driven by the TX serializer.
interface ttuart_tx_arbiter_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]   req_valid;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   req_ready;
`ifdef TTUART_ARB_LOCK_EN
   logic [NUM_REQ-1:0]   req_last;
`endif
   logic                 tx_do;
   logic [7:0]           tx_data;
   logic                 tx_data_done;

   // Arbiter view: consumes requests, drives the TX launch.
   modport slave (
`ifdef TTUART_ARB_LOCK_EN
      input  req_last,
`endif
      input  req_valid,
      input  req_data,
      output req_ready,
      output tx_do,
      output tx_data,
      input  tx_data_done
   );

   // Environment view: requesters plus the TX serializer.
   modport master (
`ifdef TTUART_ARB_LOCK_EN
      output req_last,
`endif
      output req_valid,
      output req_data,
      input  req_ready,
      input  tx_do,
      input  tx_data,
      output tx_data_done
   );
endinterface

// File: rtl/ttuart_tx_arbiter.sv
// Round-robin sharing of one 8N1 UART TX among NUM_REQ byte requesters; TTUART_ARB_LOCK_EN adds multi-byte grant locking.
// Latency: tx_do one cycle after accept; consecutive launches are at least frame time + 2 cycles apart.
// Backpressure: req_ready only in IDLE with the TX idle; a WAIT_BUSY timeout of 4 cycles drops the frame.
module ttuart_tx_arbiter #(
   parameter  int NUM_REQ = 4,   // legal range 2..8; must match the interface NUM_REQ
   parameter  int CNT_W   = 16,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst_n,
   ttuart_tx_arbiter_if.slave bus,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               busy,
   output logic [CNT_W-1:0]   sent_cnt
);

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_LAUNCH    = 2'd1;
   localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
   localparam logic [1:0] ST_WAIT_DONE = 2'd3;

   localparam logic [IDX_W-1:0] RR_RST = IDX_W'(NUM_REQ - 1);

   logic [1:0]       state;
   logic [IDX_W-1:0] rr_ptr;
   logic [1:0]       wb_cnt;      // cycles spent in WAIT_BUSY with the TX still idle
   logic             tx_do_q;
   logic [7:0]       tx_data_q;
   logic             win_found;
   logic [IDX_W-1:0] win_idx;
   logic [IDX_W-1:0] cand;
   logic             accept;
`ifdef TTUART_ARB_LOCK_EN
   logic             lock;
`endif

   // Round-robin search starting just after the last served requester; a held lock pins the search.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
         if (!win_found && bus.req_valid[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
`ifdef TTUART_ARB_LOCK_EN
      if (lock) begin
         win_found = bus.req_valid[grant_idx];
         win_idx   = grant_idx;
      end
`endif
   end

   assign accept        = (state == ST_IDLE) && bus.tx_data_done && win_found;
   assign bus.req_ready = accept ? (NUM_REQ'(1) << win_idx) : '0;
   assign bus.tx_do     = tx_do_q;
   assign bus.tx_data   = tx_data_q;
   assign busy          = (state != ST_IDLE);

   // Frame-tracking FSM, launch strobe, captured byte and completion counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         rr_ptr    <= RR_RST;
         wb_cnt    <= '0;
         tx_do_q   <= 1'b0;
         tx_data_q <= 8'h00;
         grant_idx <= '0;
         sent_cnt  <= '0;
`ifdef TTUART_ARB_LOCK_EN
         lock      <= 1'b0;
`endif
      end else begin
         tx_do_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  tx_data_q <= bus.req_data[{win_idx, 3'b000} +: 8];
                  grant_idx <= win_idx;
                  rr_ptr    <= win_idx;
                  tx_do_q   <= 1'b1;
                  state     <= ST_LAUNCH;
`ifdef TTUART_ARB_LOCK_EN
                  // Arbitration only runs in IDLE, so setting the lock from req_last now is
                  // equivalent to releasing it when a last byte completes.
                  lock      <= ~bus.req_last[win_idx];
`endif
               end
            end
            ST_LAUNCH: begin
               wb_cnt <= '0;
               state  <= ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
               if (!bus.tx_data_done) begin
                  state <= ST_WAIT_DONE;
               end else if (wb_cnt == 2'd3) begin
                  // TX never picked the byte up: drop the frame without counting it.
                  state <= ST_IDLE;
`ifdef TTUART_ARB_LOCK_EN
                  lock  <= 1'b0;
`endif
               end else begin
                  wb_cnt <= wb_cnt + 2'd1;
               end
            end
            ST_WAIT_DONE: begin
               if (bus.tx_data_done) begin
                  sent_cnt <= sent_cnt + 1'b1;
                  state    <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
